// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/stop sequencer for a CPU core.
// Holds the CPU in reset for RST_HOLD cycles after rst, then accepts
// HALT / RUN / STEP / RUN_N commands and gates cpu_ce accordingly.
// Every output is a flop whose next value is derived from the next state.
// Optional feature: define RUN_CTRL_WDOG_EN to bound free-running RUN to
// WDOG_LIMIT cycles and report the stop on wdog_flag.
module cpu_run_ctrl #(
  parameter int CNT_W      = 22,
  parameter int RST_HOLD   = 4,
  parameter int WDOG_LIMIT = 500
) (
  input  logic             inclk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cpu_halt_req,
  output logic             cpu_ce,
  output logic             cpu_rstn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles,
  output logic             wdog_flag
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_COUNT = 2'd3
  } state_e;

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_RUN_N = 2'b11;

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic               cpu_ce_q, cpu_ce_d;
  logic               cpu_rstn_q, cpu_rstn_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wdog_flag_q, wdog_flag_d;
  logic               accept;
  logic               wdog_expire;
  logic               stop;

  assign accept = cmd_valid & cmd_ready_q;

  // Any single stop source, or several together, collapses into one stop.
  assign stop = (accept && (cmd_op == OP_HALT)) || cpu_halt_req ||
                ((state_q == S_COUNT) && (rem_q == CNT_W'(1))) || wdog_expire;

`ifdef RUN_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;

  assign wdog_expire = (state_q == S_RUN) && (wdog_cnt_q == WD_W'(WDOG_LIMIT - 1));
  assign wdog_cnt_d  = (state_q == S_RUN) ? wdog_cnt_q + WD_W'(1) : '0;

  // Flag is set by an expiry and cleared by the next accepted command.
  always_comb begin
    wdog_flag_d = wdog_flag_q;
    if (wdog_expire)  wdog_flag_d = 1'b1;
    else if (accept)  wdog_flag_d = 1'b0;
  end

  // Consecutive-RUN-cycle counter; restarts at zero every time RUN is entered.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) wdog_cnt_q <= '0;
    else     wdog_cnt_q <= wdog_cnt_d;
  end
`else
  // Watchdog not built in: RUN is unbounded and the flag never rises.
  assign wdog_expire = (WDOG_LIMIT < 0);
  assign wdog_flag_d = 1'b0;
`endif

  // Next-state logic for the run sequencer.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_IDLE;
        else                     hold_d  = hold_q + HOLD_W'(1);
      end
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_HALT: done_d = 1'b1;
            OP_RUN:  state_d = S_RUN;
            OP_STEP: begin
              state_d = S_COUNT;
              rem_d   = CNT_W'(1);
            end
            OP_RUN_N: begin
              if (cmd_cnt == '0) begin
                done_d = 1'b1;
              end else begin
                state_d = S_COUNT;
                rem_d   = cmd_cnt;
              end
            end
            default: state_d = state_q;
          endcase
        end
      end
      S_RUN, S_COUNT: begin
        if (state_q == S_COUNT) rem_d = rem_q - CNT_W'(1);
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    cpu_ce_d    = (state_d == S_RUN) || (state_d == S_COUNT);
    cpu_rstn_d  = (state_d != S_HOLD);
    cmd_ready_d = (state_d != S_HOLD);
    busy_d      = (state_d != S_IDLE);
    cycles_d    = cycles_q;
    if (cpu_ce_q) cycles_d = cycles_q + CNT_W'(1);
  end

  // Control and output registers, all forced by the asynchronous reset.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      cpu_ce_q    <= 1'b0;
      cpu_rstn_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      cycles_q    <= '0;
      wdog_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cpu_ce_q    <= cpu_ce_d;
      cpu_rstn_q  <= cpu_rstn_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cycles_q    <= cycles_d;
      wdog_flag_q <= wdog_flag_d;
    end
  end

  // Remaining-cycle count is only read in COUNT, which always loads it first.
  always_ff @(posedge inclk) begin
    rem_q <= rem_d;
  end

  assign cpu_ce    = cpu_ce_q;
  assign cpu_rstn  = cpu_rstn_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycles    = cycles_q;
  assign wdog_flag = wdog_flag_q;

endmodule
